// File: rtl/seq_1011_tx.sv
// Serial frame transmitter: sync word 1011, payload MSB first, even parity, then GAP idle zeros.
// Every output is a register loaded from the next-state logic, so y and its flags change only on clk.
module seq_1011_tx #(
    parameter int DATA_W = 8,
    parameter int GAP    = 2
) (
    input  logic              clk,
    input  logic              res_n,
    input  logic              valid,
    input  logic [DATA_W-1:0] din,
    output logic              ready,
    output logic              y,
    output logic              tx_active,
    output logic              sof
);

    localparam int CW_A = (DATA_W > GAP) ? DATA_W : GAP;
    localparam int CW   = (CW_A > 4) ? CW_A : 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_DATA,
        S_PAR,
        S_GAP
    } state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic              par, par_n;
    logic              y_n, sof_n, tx_active_n, ready_n;
    logic              accept;

    assign accept = valid & ready;

    // state names the bit currently on y; cnt counts the bits left in that state after this one
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        shreg_n     = shreg;
        par_n       = par;
        y_n         = 1'b0;
        sof_n       = 1'b0;
        tx_active_n = 1'b0;
        ready_n     = 1'b0;

        case (state)
            S_IDLE: begin
                ready_n = 1'b1;
            end
            S_SYNC: begin
                tx_active_n = 1'b1;
                if (cnt != '0) begin
                    cnt_n = cnt - CW'(1);
                    y_n   = (cnt != CW'(3));
                end else begin
                    state_n = S_DATA;
                    cnt_n   = CW'(DATA_W - 1);
                    y_n     = shreg[DATA_W-1];
                    shreg_n = shreg << 1;
                    par_n   = par ^ shreg[DATA_W-1];
                end
            end
            S_DATA: begin
                tx_active_n = 1'b1;
                if (cnt != '0) begin
                    cnt_n   = cnt - CW'(1);
                    y_n     = shreg[DATA_W-1];
                    shreg_n = shreg << 1;
                    par_n   = par ^ shreg[DATA_W-1];
                end else begin
                    state_n = S_PAR;
                    y_n     = par;
                end
            end
            S_PAR: begin
                state_n = S_GAP;
                cnt_n   = CW'(GAP - 1);
                ready_n = (GAP == 1);
            end
            S_GAP: begin
                if (cnt != '0) begin
                    cnt_n   = cnt - CW'(1);
                    ready_n = (cnt == CW'(1));
                end else begin
                    state_n = S_IDLE;
                    ready_n = 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
                ready_n = 1'b1;
            end
        endcase

        // ready is only high in IDLE or the final GAP cycle, so accept overrides both
        if (accept) begin
            state_n     = S_SYNC;
            cnt_n       = CW'(3);
            shreg_n     = din;
            par_n       = 1'b0;
            y_n         = 1'b1;
            sof_n       = 1'b1;
            tx_active_n = 1'b1;
            ready_n     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            shreg     <= '0;
            par       <= 1'b0;
            y         <= 1'b0;
            sof       <= 1'b0;
            tx_active <= 1'b0;
            ready     <= 1'b1;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            shreg     <= shreg_n;
            par       <= par_n;
            y         <= y_n;
            sof       <= sof_n;
            tx_active <= tx_active_n;
            ready     <= ready_n;
        end
    end

endmodule

// File: tb/tb_seq_1011_tx.sv
// Directed bench for seq_1011_tx at default parameters (DATA_W=8, GAP=2).
// Inputs change just after a falling edge; outputs are sampled at the following falling edge.
module tb_seq_1011_tx;

    logic       clk;
    logic       res_n;
    logic       valid;
    logic [7:0] din;
    logic       ready;
    logic       y;
    logic       tx_active;
    logic       sof;

    int tests;
    int fails;

    seq_1011_tx #(.DATA_W(8), .GAP(2)) dut (
        .clk       (clk),
        .res_n     (res_n),
        .valid     (valid),
        .din       (din),
        .ready     (ready),
        .y         (y),
        .tx_active (tx_active),
        .sof       (sof)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        res_n = 1'b0;
        valid = 1'b1;
        din   = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if ({y, ready, tx_active, sof} !== 4'b0100) begin
                fails++;
                $display("[TB] FAIL reset[%0d] y/ready/tx_active/sof got %b want 0100", i, {y, ready, tx_active, sof});
            end
        end
        valid = 1'b0;
        res_n = 1'b1;
        @(negedge clk);
        tests++;
        if ({y, ready, tx_active, sof} !== 4'b0100) begin
            fails++;
            $display("[TB] FAIL reset_release got %b want 0100", {y, ready, tx_active, sof});
        end
    endtask

    // Accepts one payload and checks 15 cycles of y/sof/tx_active/ready against exp (cycle 0 = bit 14).
    task automatic test_frame(input string name, input logic [7:0] payload, input logic [14:0] exp,
                              input bit poke_busy);
        @(negedge clk);
        valid = 1'b1;
        din   = payload;
        @(negedge clk);
        valid = 1'b0;
        din   = 8'h00;
        for (int c = 0; c < 15; c++) begin
            tests++;
            if (y !== exp[14-c]) begin
                fails++;
                $display("[TB] FAIL %s y[%0d] got %b want %b", name, c, y, exp[14-c]);
            end
            tests++;
            if (sof !== (c == 0)) begin
                fails++;
                $display("[TB] FAIL %s sof[%0d] got %b want %b", name, c, sof, (c == 0));
            end
            tests++;
            if (tx_active !== (c <= 12)) begin
                fails++;
                $display("[TB] FAIL %s tx_active[%0d] got %b want %b", name, c, tx_active, (c <= 12));
            end
            tests++;
            if (ready !== (c == 14)) begin
                fails++;
                $display("[TB] FAIL %s ready[%0d] got %b want %b", name, c, ready, (c == 14));
            end
            if (poke_busy && c == 6) begin
                valid = 1'b1;
                din   = 8'hFF;
            end else begin
                valid = 1'b0;
                din   = 8'h00;
            end
            @(negedge clk);
        end
        for (int c = 15; c < 18; c++) begin
            tests++;
            if ({y, ready, tx_active, sof} !== 4'b0100) begin
                fails++;
                $display("[TB] FAIL %s idle[%0d] got %b want 0100", name, c, {y, ready, tx_active, sof});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [29:0] exp;
        exp = {4'b1011, 8'b00111100, 1'b0, 2'b00, 4'b1011, 8'b11000011, 1'b0, 2'b00};
        @(negedge clk);
        valid = 1'b1;
        din   = 8'h3C;
        @(negedge clk);
        din = 8'hC3;
        for (int c = 0; c < 30; c++) begin
            tests++;
            if (y !== exp[29-c]) begin
                fails++;
                $display("[TB] FAIL b2b y[%0d] got %b want %b", c, y, exp[29-c]);
            end
            tests++;
            if (sof !== (c == 0 || c == 15)) begin
                fails++;
                $display("[TB] FAIL b2b sof[%0d] got %b want %b", c, sof, (c == 0 || c == 15));
            end
            tests++;
            if (ready !== (c == 14 || c == 29)) begin
                fails++;
                $display("[TB] FAIL b2b ready[%0d] got %b want %b", c, ready, (c == 14 || c == 29));
            end
            tests++;
            if (tx_active !== ((c % 15) <= 12)) begin
                fails++;
                $display("[TB] FAIL b2b tx_active[%0d] got %b want %b", c, tx_active, ((c % 15) <= 12));
            end
            if (c == 15) valid = 1'b0;
            @(negedge clk);
        end
        tests++;
        if ({y, ready, sof} !== 3'b010) begin
            fails++;
            $display("[TB] FAIL b2b tail got %b want 010", {y, ready, sof});
        end
    endtask

    task automatic test_mid_reset();
        logic [14:0] exp_a;
        exp_a = {4'b1011, 8'hA5, 1'b0, 2'b00};
        @(negedge clk);
        valid = 1'b1;
        din   = 8'hA5;
        @(negedge clk);
        valid = 1'b0;
        for (int c = 0; c <= 6; c++) begin
            tests++;
            if (y !== exp_a[14-c]) begin
                fails++;
                $display("[TB] FAIL midrst y[%0d] got %b want %b", c, y, exp_a[14-c]);
            end
            if (c < 6) @(negedge clk);
        end
        res_n = 1'b0;
        @(negedge clk);
        tests++;
        if ({y, ready, tx_active, sof} !== 4'b0100) begin
            fails++;
            $display("[TB] FAIL midrst abort got %b want 0100", {y, ready, tx_active, sof});
        end
        res_n = 1'b1;
        @(negedge clk);
        tests++;
        if ({y, tx_active} !== 2'b00) begin
            fails++;
            $display("[TB] FAIL midrst stale got %b want 00", {y, tx_active});
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        res_n = 1'b0;
        valid = 1'b0;
        din   = 8'h00;
        test_reset();
        test_frame("single_a5", 8'hA5, {4'b1011, 8'b10100101, 1'b0, 2'b00}, 1'b0);
        test_frame("odd_par_07", 8'h07, {4'b1011, 8'b00000111, 1'b1, 2'b00}, 1'b0);
        test_back_to_back();
        test_frame("busy_ignore", 8'h00, {4'b1011, 8'b00000000, 1'b0, 2'b00}, 1'b1);
        test_mid_reset();
        test_frame("post_reset_5a", 8'h5A, {4'b1011, 8'b01011010, 1'b0, 2'b00}, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
